sseg_scan_decoder: RTL

//   Receive-side counterpart of the hex-to-seven-segment encoder ROM.

---
 rtl/sseg_scan_decoder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sseg_scan_decoder.sv
// Seven-segment scan decoder: watches a multiplexed 4-digit display bus and rebuilds the hex frame.
// Latency: a digit registered at edge k is sampled at edge k+SETTLE; frame_tick is high the cycle after.
// Backpressure: none; the consumer must capture hex/dp/err while frame_tick is high.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   an[3:0]         active-low digit enables (an[i]=0 selects digit i)
//   sseg[7:0]       active-low segments, [7]=dp, [6:0]=a..g
//   hex[15:0]       decoded frame, digit i in hex[4i+3:4i]
//   dp[3:0]         active-high decimal points of the frame
//   err[3:0]        err[i]=1 when digit i's pattern is not a hex glyph
//   frame_tick      one-cycle pulse when hex/dp/err update
module sseg_scan_decoder #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [7:0]  sseg,
  output logic [15:0] hex,
  output logic [3:0]  dp,
  output logic [3:0]  err,
  output logic        frame_tick
);

  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_PRE = CW'(SETTLE - 1);

  // Returns {no_match, nibble}; unknown patterns decode to nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b0000001: r = 5'h00;
      7'b1001111: r = 5'h01;
      7'b0010010: r = 5'h02;
      7'b0000110: r = 5'h03;
      7'b1001100: r = 5'h04;
      7'b0100100: r = 5'h05;
      7'b0100000: r = 5'h06;
      7'b0001111: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0000100: r = 5'h09;
      7'b0001000: r = 5'h0A;
      7'b1100000: r = 5'h0B;
      7'b0110001: r = 5'h0C;
      7'b1000010: r = 5'h0D;
      7'b0110000: r = 5'h0E;
      7'b0111000: r = 5'h0F;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  logic [3:0]    an_reg;
  logic [7:0]    sseg_reg;
  logic [CW-1:0] cnt;
  logic [3:0]    seen;
  logic [15:0]   buf_hex;
  logic [3:0]    buf_dp;
  logic [3:0]    buf_err;

  logic          in_change;
  logic          onehot;
  logic          sample;
  logic [3:0]    sel;
  logic [4:0]    dec;
  logic [15:0]   nxt_hex;
  logic [3:0]    nxt_dp;
  logic [3:0]    nxt_err;
  logic [3:0]    nxt_seen;

  always_comb begin
    in_change = ({an, sseg} != {an_reg, sseg_reg});
    sel       = ~an_reg;
    // Exactly one digit enabled: sel non-zero and a power of two.
    onehot    = (sel != 4'b0000) && ((sel & (sel - 4'b0001)) == 4'b0000);
    // The SETTLE-1 -> SETTLE step happens once per dwell; a change edge
    // resets the count instead, so it never samples.
    sample    = !in_change && (cnt == CNT_PRE) && onehot;
    dec       = decode(sseg_reg[6:0]);
    nxt_hex   = buf_hex;
    nxt_dp    = buf_dp;
    nxt_err   = buf_err;
    nxt_seen  = seen | sel;
    // sel is one-hot whenever the result is used, so it doubles as the slot mask.
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        nxt_hex[4*i +: 4] = dec[3:0];
        nxt_dp[i]         = ~sseg_reg[7];
        nxt_err[i]        = dec[4];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_reg     <= 4'hF;
      sseg_reg   <= 8'hFF;
      cnt        <= '0;
      seen       <= 4'b0000;
      buf_hex    <= 16'h0000;
      buf_dp     <= 4'b0000;
      buf_err    <= 4'b0000;
      hex        <= 16'h0000;
      dp         <= 4'b0000;
      err        <= 4'b0000;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;

      if (in_change) begin
        an_reg   <= an;
        sseg_reg <= sseg;
        cnt      <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end

      if (sample) begin
        buf_hex <= nxt_hex;
        buf_dp  <= nxt_dp;
        buf_err <= nxt_err;
        if (nxt_seen == 4'hF) begin
          // Completing digit is folded into the published frame.
          hex        <= nxt_hex;
          dp         <= nxt_dp;
          err        <= nxt_err;
          frame_tick <= 1'b1;
          seen       <= 4'b0000;
        end else begin
          seen <= nxt_seen;
        end
      end
    end
  end

endmodule
